// File: rtl/usb_receiver.sv
// usb_receiver
//   Full-speed USB receive path. D+/D- are synchronized, bit timing is
//   recovered with a counter that restarts on every line transition, bits are
//   NRZI-decoded and unstuffed, and SYNC/PID/payload/EOP are framed.
//
// Ports
//   clk           96 MHz system clock
//   rst           asynchronous, active-high reset
//   d_plus        raw D+ line (asynchronous)
//   d_minus       raw D- line (asynchronous)
//   rcving        high from SYNC start to end of packet or error recovery
//   rx_pid        PID of the current packet, held until the next PID
//   pid_valid     one-cycle pulse when a PID passes its check
//   rx_data       payload byte, LSB received first (CRC bytes included)
//   rx_data_valid one-cycle write strobe for rx_data
//   rx_done       one-cycle pulse on a clean EOP
//   rx_error      sticky error flag, cleared when the next SYNC starts
//
// Build option
//   USB_RX_CRC16_EN : check CRC-16 over DATA0/DATA1 payloads; a bad residual
//                     sets rx_error and suppresses rx_done.
module usb_receiver #(
    parameter int unsigned BIT_CLKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic       rcving,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_done,
    output logic       rx_error
);
    localparam int unsigned   CW        = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] SAMPLE_PT = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(BIT_CLKS - 1);

    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} line_t;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_ERR} state_t;

    logic          dp_meta_q, dp_q, dm_meta_q, dm_q;
    line_t         line_w, line_prev_q, samp_prev_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, byte_w;
    logic [2:0]    bitcnt_q, ones_q, err_jcnt_q;
    logic          eop_wait_j_q, err_se0_q;
    logic          sample_w, bit_w, pid_ok_w;
`ifdef USB_RX_CRC16_EN
    localparam logic [15:0] CRC_POLY     = 16'h8005;
    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;
    logic [15:0] crc_q;
    logic        crc_on_q;
`endif

    // Synchronizers idle at J so reset never produces a false K.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_meta_q <= 1'b1;
            dp_q      <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_q      <= 1'b0;
        end else begin
            dp_meta_q <= d_plus;
            dp_q      <= dp_meta_q;
            dm_meta_q <= d_minus;
            dm_q      <= dm_meta_q;
        end
    end

    always_comb begin
        if (dp_q && !dm_q)      line_w = LS_J;
        else if (!dp_q && dm_q) line_w = LS_K;
        else                    line_w = LS_SE0;
    end

    // Bit-phase counter: held in IDLE, realigned on every line change.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == S_IDLE || line_w != line_prev_q || cnt_q == LAST_CNT)
            cnt_d = '0;
    end

    assign sample_w = (state_q != S_IDLE) && (cnt_q == SAMPLE_PT);
    assign bit_w    = (line_w == samp_prev_q);     // NRZI: no change is a 1
    assign byte_w   = {bit_w, shift_q[7:1]};
    assign pid_ok_w = (byte_w[7:4] == ~byte_w[3:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            line_prev_q   <= LS_J;
            samp_prev_q   <= LS_J;
            shift_q       <= '0;
            bitcnt_q      <= '0;
            ones_q        <= '0;
            eop_wait_j_q  <= 1'b0;
            err_se0_q     <= 1'b0;
            err_jcnt_q    <= '0;
            rcving        <= 1'b0;
            rx_pid        <= '0;
            pid_valid     <= 1'b0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_done       <= 1'b0;
            rx_error      <= 1'b0;
`ifdef USB_RX_CRC16_EN
            crc_q         <= '1;
            crc_on_q      <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            line_prev_q   <= line_w;
            pid_valid     <= 1'b0;
            rx_data_valid <= 1'b0;
            rx_done       <= 1'b0;
            if (state_q != S_ERR) begin
                err_se0_q  <= 1'b0;
                err_jcnt_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (line_w == LS_K) begin
                        state_q     <= S_SYNC;
                        rcving      <= 1'b1;
                        rx_error    <= 1'b0;
                        samp_prev_q <= LS_J;   // first K decodes as a 0
                        ones_q      <= '0;
                        bitcnt_q    <= '0;
                    end
                end

                S_SYNC, S_PID, S_DATA: begin
                    if (sample_w) begin
                        if (line_w == LS_SE0) begin
                            if (state_q == S_DATA && bitcnt_q == 3'd0) begin
                                state_q      <= S_EOP;
                                eop_wait_j_q <= 1'b0;
                            end else begin
                                state_q  <= S_ERR;
                                rx_error <= 1'b1;
                            end
                        end else begin
                            samp_prev_q <= line_w;
                            if (ones_q == 3'd6) begin
                                // Stuffed position: a 0 is dropped, a 1 is illegal.
                                ones_q <= '0;
                                if (bit_w) begin
                                    state_q  <= S_ERR;
                                    rx_error <= 1'b1;
                                end
                            end else begin
                                ones_q   <= bit_w ? ones_q + 3'd1 : 3'd0;
                                shift_q  <= byte_w;
                                bitcnt_q <= bitcnt_q + 3'd1;
`ifdef USB_RX_CRC16_EN
                                if (state_q == S_DATA && crc_on_q)
                                    crc_q <= {crc_q[14:0], 1'b0} ^
                                             ((bit_w ^ crc_q[15]) ? CRC_POLY : 16'h0000);
`endif
                                if (bitcnt_q == 3'd7) begin
                                    case (state_q)
                                        S_SYNC: begin
                                            if (byte_w == 8'h80) begin
                                                state_q <= S_PID;
                                            end else begin
                                                state_q  <= S_ERR;
                                                rx_error <= 1'b1;
                                            end
                                        end
                                        S_PID: begin
                                            if (pid_ok_w) begin
                                                pid_valid <= 1'b1;
                                                rx_pid    <= byte_w[3:0];
                                                state_q   <= S_DATA;
`ifdef USB_RX_CRC16_EN
                                                crc_q    <= '1;
                                                crc_on_q <= (byte_w[3:0] == 4'h3) ||
                                                            (byte_w[3:0] == 4'hB);
`endif
                                            end else begin
                                                state_q  <= S_ERR;
                                                rx_error <= 1'b1;
                                            end
                                        end
                                        default: begin
                                            rx_data       <= byte_w;
                                            rx_data_valid <= 1'b1;
                                        end
                                    endcase
                                end
                            end
                        end
                    end
                end

                S_EOP: begin
                    if (sample_w) begin
                        if (!eop_wait_j_q) begin
                            if (line_w == LS_SE0) begin
                                eop_wait_j_q <= 1'b1;
                            end else begin
                                state_q  <= S_ERR;
                                rx_error <= 1'b1;
                            end
                        end else if (line_w == LS_J) begin
`ifdef USB_RX_CRC16_EN
                            if (crc_on_q && crc_q != CRC_RESIDUAL) begin
                                state_q  <= S_ERR;
                                rx_error <= 1'b1;
                            end else
`endif
                            begin
                                rx_done <= 1'b1;
                                rcving  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            state_q  <= S_ERR;
                            rx_error <= 1'b1;
                        end
                    end
                end

                S_ERR: begin
                    // Leave on SE0 then J, or after 8 consecutive J bit times.
                    if (sample_w) begin
                        case (line_w)
                            LS_SE0: begin
                                err_se0_q  <= 1'b1;
                                err_jcnt_q <= '0;
                            end
                            LS_J: begin
                                if (err_se0_q || err_jcnt_q == 3'd7) begin
                                    state_q <= S_IDLE;
                                    rcving  <= 1'b0;
                                end else begin
                                    err_jcnt_q <= err_jcnt_q + 3'd1;
                                end
                            end
                            default: begin
                                err_se0_q  <= 1'b0;
                                err_jcnt_q <= '0;
                            end
                        endcase
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_receiver.sv
// Scoreboard bench for usb_receiver: packets are encoded onto the line
// (bit stuffing + NRZI, 8 clocks per bit) and the expected PID/byte/done
// events are queued; a monitor pops and compares as strobes appear.
module tb_usb_receiver;
    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus, d_minus;
    logic       rcving, pid_valid, rx_data_valid, rx_done, rx_error;
    logic [3:0] rx_pid;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    usb_receiver #(.BIT_CLKS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .rcving       (rcving),
        .rx_pid       (rx_pid),
        .pid_valid    (pid_valid),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_done      (rx_done),
        .rx_error     (rx_error)
    );

    localparam int unsigned EV_PID = 0, EV_DATA = 1, EV_DONE = 2;
    typedef struct {
        int unsigned kind;
        logic [7:0]  val;
    } ev_t;

    ev_t         expq[$];
    logic [7:0]  pl[$];
    int          checks = 0;
    int          errors = 0;
    bit          lvl_j;
    int unsigned ones;
    int unsigned cyc = 0, pid_cyc = 0, gap1 = 0;
    bit          after_pid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int unsigned k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic mon_event(input int unsigned k, input logic [7:0] v);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0h expected none", k, v);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.val !== v) begin
                errors++;
                $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pid_valid) begin
                mon_event(EV_PID, {4'h0, rx_pid});
                pid_cyc   = cyc;
                after_pid = 1'b1;
            end
            if (rx_data_valid) begin
                mon_event(EV_DATA, rx_data);
                if (after_pid) begin
                    gap1      = cyc - pid_cyc;
                    after_pid = 1'b0;
                end
            end
            if (rx_done) mon_event(EV_DONE, 8'h00);
        end
    end

    task automatic drive_line(input logic dp, input logic dm, input int unsigned n);
        d_plus  = dp;
        d_minus = dm;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int unsigned n);
        drive_line(1'b1, 1'b0, n);
    endtask

    task automatic send_nrzi(input bit b);
        if (!b) lvl_j = ~lvl_j;
        drive_line(lvl_j, ~lvl_j, 8);
    endtask

    task automatic send_bit(input bit b, input bit stuff_en);
        send_nrzi(b);
        ones = b ? ones + 1 : 0;
        if (stuff_en && ones == 6) begin
            send_nrzi(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit stuff_en);
        for (int i = 0; i < 8; i++) send_bit(v[i], stuff_en);
    endtask

    task automatic start_packet();
        lvl_j = 1'b1;
        ones  = 0;
        send_byte(8'h80, 1'b1);
    endtask

    task automatic send_eop();
        drive_line(1'b0, 1'b0, 16);
        drive_line(1'b1, 1'b0, 8);
        lvl_j = 1'b1;
    endtask

    task automatic post_check(input string tag, input bit exp_err);
        check({tag, "_rcving"}, rcving, 0);
        check({tag, "_rx_error"}, rx_error, exp_err);
        check({tag, "_pending_events"}, expq.size(), 0);
        expq.delete();
    endtask

    // CRC-16 of the payload, transmitted complemented and MSB first.
    task automatic append_crc(input bit flip);
        logic [15:0] c;
        logic [7:0]  b0, b1;
        logic        fb;
        c = 16'hFFFF;
        foreach (pl[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = pl[i][k] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        c = ~c;
        for (int k = 0; k < 8; k++) begin
            b0[k] = c[15-k];
            b1[k] = c[7-k];
        end
        if (flip) b0[0] = ~b0[0];
        pl.push_back(b0);
        pl.push_back(b1);
    endtask

    task automatic send_good(input string tag, input logic [3:0] p);
`ifdef USB_RX_CRC16_EN
        if (p == 4'h3 || p == 4'hB) append_crc(1'b0);
`endif
        push_ev(EV_PID, {4'h0, p});
        foreach (pl[i]) push_ev(EV_DATA, pl[i]);
        push_ev(EV_DONE, 8'h00);
        start_packet();
        check({tag, "_rcving_in_sync"}, rcving, 1);
        check({tag, "_error_cleared"}, rx_error, 0);
        send_byte({~p, p}, 1'b1);
        foreach (pl[i]) send_byte(pl[i], 1'b1);
        send_eop();
        idle(120);
        post_check(tag, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        lvl_j = 1'b1;
        ones = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle(100);
        check("reset_rcving", rcving, 0);
        check("reset_rx_error", rx_error, 0);
        check("reset_pid_valid", pid_valid, 0);
        check("reset_rx_pid", rx_pid, 0);
        check("reset_rx_data_valid", rx_data_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_done", rx_done, 0);

        // OUT token
        pl.delete();
        pl.push_back(8'h00);
        pl.push_back(8'h10);
        send_good("out_token", 4'h1);
        check("out_rx_pid_held", rx_pid, 4'h1);

        // DATA0 with 0xFF: one stuffed bit stretches the byte to 9 bit times
        pl.delete();
        pl.push_back(8'hFF);
        send_good("stuffing", 4'h3);
        check("stuff_strobe_gap", gap1, 72);

        // Seven 1s in a row: stuff error, no further strobes
        expq.delete();
        push_ev(EV_PID, 8'h03);
        start_packet();
        send_byte(8'hC3, 1'b1);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h55, 1'b0);
        send_eop();
        idle(120);
        post_check("stuff_error", 1'b1);

        // Clean packet clears the sticky error at SYNC
        pl.delete();
        pl.push_back(8'hA5);
        send_good("recover", 4'h9);

        // SE0 after three payload bits
        push_ev(EV_PID, 8'h03);
        start_packet();
        send_byte(8'hC3, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_eop();
        idle(120);
        post_check("se0_midbyte", 1'b1);

        // Bad PID
        start_packet();
        send_byte(8'hE0, 1'b1);
        send_byte(8'h12, 1'b1);
        send_eop();
        idle(120);
        post_check("bad_pid", 1'b1);

        // Reset in the middle of a payload byte
        push_ev(EV_PID, 8'h09);
        start_packet();
        send_byte(8'h69, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        rst = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midreset_rcving", rcving, 0);
        check("midreset_rx_error", rx_error, 0);
        rst = 1'b0;
        lvl_j = 1'b1;
        idle(120);
        post_check("midreset", 1'b0);

        // Randomized packets
        for (int n = 0; n < 20; n++) begin
            pl.delete();
            repeat ($urandom_range(0, 4)) pl.push_back(8'($urandom));
            send_good("random", 4'($urandom_range(0, 15)));
            idle($urandom_range(1, 30));
        end

`ifdef USB_RX_CRC16_EN
        pl.delete();
        pl.push_back(8'h01);
        pl.push_back(8'h02);
        send_good("crc_good", 4'hB);

        pl.delete();
        pl.push_back(8'h01);
        pl.push_back(8'h02);
        append_crc(1'b1);
        push_ev(EV_PID, 8'h0B);
        foreach (pl[i]) push_ev(EV_DATA, pl[i]);
        start_packet();
        send_byte(8'h4B, 1'b1);
        foreach (pl[i]) send_byte(pl[i], 1'b1);
        send_eop();
        idle(150);
        post_check("crc_bad", 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_receiver.md
# usb_receiver

Full-speed USB receive path: recovers bits from the D+/D− pair sampled at 96 MHz (8 clocks per 12 Mbps bit), NRZI-decodes, removes stuffed bits, detects SYNC/PID/EOP and delivers payload bytes to the packet buffer. It is the receive-side counterpart of `usb_transmitter`. It feeds the buffer write port and the protocol controller's PID/ack logic.

## Interface
- `BIT_CLKS`, 8: clocks per bit period; the sample point is `BIT_CLKS/2 − 1`.
- `clk`  in  1  96 MHz system clock
- `rst`  in  1  asynchronous, active-high reset
- `d_plus`  in  1  raw D+ line; asynchronous to `clk`
- `d_minus`  in  1  raw D− line; asynchronous to `clk`
- `rcving`  out  1  high from SYNC start to end of packet or error recovery
- `rx_pid`  out  4  PID of the current packet; valid while `pid_valid` is high and held until the next PID
- `pid_valid`  out  1  one-cycle pulse when a PID passes its check
- `rx_data`  out  8  payload byte, LSB received first
- `rx_data_valid`  out  1  one-cycle write strobe for `rx_data`
- `rx_done`  out  1  one-cycle pulse on a clean EOP
- `rx_error`  out  1  sticky error flag; cleared when the next SYNC starts

## Operation
- **Line sampling:** `d_plus` and `d_minus` each pass through a two-flop synchronizer.
- **Line states:** J = (1,0), K = (0,1), SE0 = (0,0); (1,1) is treated as SE0.
- **Bit timing:** a counter runs 0..`BIT_CLKS`−1 and resets to 0 on every synchronized J/K transition. A bit is sampled when the count equals 3. The counter is inactive in `IDLE` until the first K.
- **NRZI decode:** no change from the previous sampled state gives 1; a change gives 0.
- **Bit unstuffing:** after six consecutive decoded 1s, the next bit must be 0 and is discarded. If it is 1, that is a stuff error.
- **Packet framing:** bytes are shifted into a register LSB-first. The first byte must be SYNC = 0x80 (KJKJKJKK); the second byte is the PID.
- **PID check:** `pid[7:4] == ~pid[3:0]` is required, otherwise error. `rx_pid` takes `pid[3:0]`.
- **Payload:** every complete byte after the PID is strobed on `rx_data`/`rx_data_valid`. CRC bytes are included; the consumer strips them.
- **States:**
  - `IDLE`: on K go to `SYNC` and set `rcving`=1, `rx_error`=0.
  - `SYNC`: after 8 bits, 0x80 goes to `PID`; anything else goes to `ERR`.
  - `PID`: after 8 bits, a good check pulses `pid_valid` and goes to `DATA`; a bad check goes to `ERR`.
  - `DATA`: SE0 sampled at a byte boundary (bit count 0) goes to `EOP`; SE0 mid-byte goes to `ERR`; a stuff error goes to `ERR`.
  - `EOP`: a second SE0 bit followed by a J bit pulses `rx_done`, drops `rcving` and returns to `IDLE`. A missing SE0 or J goes to `ERR`.
  - `ERR`: sets `rx_error`=1 and ignores the line. Waits for SE0 followed by J, or for 8 consecutive J bit times, then drops `rcving` and returns to `IDLE`.
- **Reset:** all outputs are 0 and the FSM is in `IDLE`. The synchronizers reset to J (1,0) so that no false K is seen after reset. Reset mid-packet abandons the packet with no strobes.

## Timing
- `rx_data_valid` and `pid_valid` assert in the cycle after the sample edge of the byte's 8th (unstuffed) bit, for exactly one cycle.
- `rx_data` is stable in that cycle and holds until the next strobe.
- Input-to-sample latency is 2 synchronizer cycles plus 4 counter cycles from the edge.
- `rx_done` asserts the cycle after the sampled J that ends the EOP; `rcving` falls in the same cycle.
- A stuffed bit consumes a bit period but produces no shift.
- Byte strobes are therefore at least 64 clocks apart.

## Configuration
- **`USB_RX_CRC16_EN` defined:**
  - A CRC-16 (poly 0x8005, init 0xFFFF) runs over all `DATA`-state bits of DATA0/DATA1 packets (PID 0x3/0xB).
  - At EOP the residual must be 0x800D; otherwise `rx_error` is set and `rx_done` is suppressed.
- **Undefined:** no CRC logic is present; every EOP that is correctly framed pulses `rx_done`.

## Test plan
- **Reset and idle:** reset with the line idle at J for 100 clocks → all outputs 0, `rcving`=0.
- **OUT token:** SYNC, PID 0xE1, bytes 0x00 0x10, EOP → `pid_valid` pulse with `rx_pid`=0x1; two `rx_data_valid` strobes (0x00, 0x10); `rx_done` pulse; `rcving` falls.
- **Bit stuffing:** DATA0 (PID 0xC3) carrying byte 0xFF, so a stuffed 0 appears after six 1s → `rx_data`=0xFF; strobe 72 clocks after the previous one; no error.
- **Stuff and framing errors:**
  - Seven consecutive 1s → `rx_error`=1 and no further strobes.
  - A later clean packet clears `rx_error` at SYNC.
  - SE0 after 3 payload bits → `rx_error`=1, no `rx_done`.
- **Bad PID:** PID byte 0xE0 → no `pid_valid`, `rx_error`=1; recovery to `IDLE` after EOP.
- **CRC (`USB_RX_CRC16_EN` defined):**
  - DATA1 with payload 0x01 0x02 and correct CRC bytes → `rx_done`.
  - The same packet with one CRC bit flipped → `rx_error`=1, no `rx_done`.
